// File: rtl/uart_rx_ctrl_if.sv
// Host read port of the receive FIFO: pop strobe plus show-ahead head entry and fill status.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             i_rd_en;
    logic [7:0]       o_rd_data;
    logic             o_rd_perr;
    logic             o_empty;
    logic             o_full;
    logic [LVL_W-1:0] o_level;

    modport master (
        output i_rd_en,
        input  o_rd_data, o_rd_perr, o_empty, o_full, o_level
    );

    modport slave (
        input  i_rd_en,
        output o_rd_data, o_rd_perr, o_empty, o_full, o_level
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: frame tracking, deferred frame-format configuration,
// character FIFO with parity flags, timeout/threshold interrupt and sticky errors.
module uart_rx_ctrl #(
    parameter int DEPTH        = 4,
    parameter int THRESH       = 2,
    parameter int TIMEOUT_BITS = 4,
    parameter int WDOG_TICKS   = 192
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_tick,
    input  logic             i_rx_serial,
    input  logic [1:0]       i_cfg_num_bit_data,
    input  logic             i_cfg_parity_en,
    input  logic             i_cfg_parity_type,
    input  logic             i_cfg_wr,
    output logic [1:0]       o_num_bit_data,
    output logic             o_parity_en,
    output logic             o_parity_type,
    output logic             o_cfg_pending,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_done,
    input  logic             i_parity_err,
    uart_rx_ctrl_if.slave    host,
    input  logic             i_clr_err,
    output logic             o_overrun,
    output logic             o_frame_to,
    output logic             o_irq
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int TO_TICKS = TIMEOUT_BITS * 16;
    localparam int TO_W     = $clog2(TO_TICKS);
    localparam int WD_W     = $clog2(WDOG_TICKS + 1);

    typedef enum logic {IDLE, FRAME} state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_sync_q;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              wdog_expire;
    logic              enter_frame;

    logic [1:0]        nbd_q, nbd_d, pend_nbd_q, pend_nbd_d;
    logic              pen_q, pen_d, pend_pen_q, pend_pen_d;
    logic              ptype_q, ptype_d, pend_ptype_q, pend_ptype_d;
    logic              pending_q, pending_d;
    logic              apply;

    logic [8:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [8:0]        head_q, head_d, wdata;
    logic              empty, full, do_push, do_pop, ovr_set;

    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              to_flag_q, to_flag_d;
    logic              overrun_q, overrun_d, frame_to_q, frame_to_d, irq_q, irq_d;

    // Frame FSM: rx_done ends the frame ahead of a simultaneous watchdog expiry.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        wdog_expire = 1'b0;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (!rx_sync_q) state_d = FRAME;
            end
            FRAME: begin
                if (i_rx_done) begin
                    state_d = IDLE;
                end else if (rx_tick) begin
                    if (wdog_q == WD_W'(WDOG_TICKS - 1)) begin
                        state_d     = IDLE;
                        wdog_expire = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_frame = (state_q == IDLE) && !rx_sync_q;

    // A write landing on the apply cycle stays pending; the older values go out.
    always_comb begin
        apply        = pending_q && (state_q == IDLE) && rx_sync_q;
        nbd_d        = apply ? pend_nbd_q   : nbd_q;
        pen_d        = apply ? pend_pen_q   : pen_q;
        ptype_d      = apply ? pend_ptype_q : ptype_q;
        pend_nbd_d   = i_cfg_wr ? i_cfg_num_bit_data : pend_nbd_q;
        pend_pen_d   = i_cfg_wr ? i_cfg_parity_en    : pend_pen_q;
        pend_ptype_d = i_cfg_wr ? i_cfg_parity_type  : pend_ptype_q;
        pending_d    = i_cfg_wr | (pending_q & ~apply);
    end

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(DEPTH));
    assign do_pop  = host.i_rd_en && !empty;
    assign do_push = i_rx_done && (!full || do_pop);
    assign ovr_set = i_rx_done && full && !host.i_rd_en;
    assign wdata   = {i_parity_err, i_rx_data};
    assign rd_next = rd_ptr_q + 1'b1;

    // FIFO bookkeeping; head_q is the show-ahead copy that holds once drained.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_next         : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        head_d = head_q;
        if (do_pop) begin
            if (level_q > LVL_W'(1)) head_d = mem_q[rd_next];
            else if (do_push)        head_d = wdata;
        end else if (do_push && empty) begin
            head_d = wdata;
        end
    end

    always_comb begin
        to_cnt_d  = to_cnt_q;
        to_flag_d = to_flag_q;
        if (do_push || do_pop || enter_frame) begin
            to_cnt_d = '0;
        end else if (!empty && (state_q == IDLE) && rx_tick && !to_flag_q) begin
            if (to_cnt_q == TO_W'(TO_TICKS - 1)) to_flag_d = 1'b1;
            else                                 to_cnt_d  = to_cnt_q + 1'b1;
        end
        if (do_pop || (level_d == '0)) to_flag_d = 1'b0;

        overrun_d  = ovr_set     ? 1'b1 : (i_clr_err ? 1'b0 : overrun_q);
        frame_to_d = wdog_expire ? 1'b1 : (i_clr_err ? 1'b0 : frame_to_q);
        irq_d      = (level_d >= LVL_W'(THRESH)) | to_flag_d | overrun_d | frame_to_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            state_q    <= IDLE;
            wdog_q     <= '0;
            nbd_q      <= 2'b11;
            pen_q      <= 1'b0;
            ptype_q    <= 1'b0;
            pending_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
            overrun_q  <= 1'b0;
            frame_to_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rx_meta_q  <= i_rx_serial;
            rx_sync_q  <= rx_meta_q;
            state_q    <= state_d;
            wdog_q     <= wdog_d;
            nbd_q      <= nbd_d;
            pen_q      <= pen_d;
            ptype_q    <= ptype_d;
            pending_q  <= pending_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_q     <= head_d;
            to_cnt_q   <= to_cnt_d;
            to_flag_q  <= to_flag_d;
            overrun_q  <= overrun_d;
            frame_to_q <= frame_to_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_nbd_q   <= pend_nbd_d;
        pend_pen_q   <= pend_pen_d;
        pend_ptype_q <= pend_ptype_d;
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign o_num_bit_data = nbd_q;
    assign o_parity_en    = pen_q;
    assign o_parity_type  = ptype_q;
    assign o_cfg_pending  = pending_q;
    assign host.o_rd_data = head_q[7:0];
    assign host.o_rd_perr = head_q[8];
    assign host.o_empty   = empty;
    assign host.o_full    = full;
    assign host.o_level   = level_q;
    assign o_overrun      = overrun_q;
    assign o_frame_to     = frame_to_q;
    assign o_irq          = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: expected characters queue up as frames are sent,
// a monitor compares them on every pop; control/status checks run inline.
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] cfg_nbd = 2'b00;
    logic       cfg_pen = 1'b0;
    logic       cfg_pt = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] nbd;
    logic       pen, pt, pending;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       perr_in = 1'b0;
    logic       clr_err = 1'b0;
    logic       overrun, frame_to, irq;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    uart_rx_ctrl_if #(.DEPTH(4)) host_if ();

    uart_rx_ctrl #(.DEPTH(4), .THRESH(2), .TIMEOUT_BITS(4), .WDOG_TICKS(192)) dut (
        .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .i_rx_serial(rx),
        .i_cfg_num_bit_data(cfg_nbd), .i_cfg_parity_en(cfg_pen),
        .i_cfg_parity_type(cfg_pt), .i_cfg_wr(cfg_wr),
        .o_num_bit_data(nbd), .o_parity_en(pen), .o_parity_type(pt),
        .o_cfg_pending(pending), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_parity_err(perr_in), .host(host_if), .i_clr_err(clr_err),
        .o_overrun(overrun), .o_frame_to(frame_to), .o_irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout_global actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the oldest expected character.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && host_if.i_rd_en && !host_if.o_empty) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop actual=%0h required=none", {host_if.o_rd_perr, host_if.o_rd_data});
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    if ({host_if.o_rd_perr, host_if.o_rd_data} !== e) begin
                        errors++;
                        $display("FAIL sb_pop actual=%0h required=%0h", {host_if.o_rd_perr, host_if.o_rd_data}, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            rx_tick = 1'b1;
            step();
            rx_tick = 1'b0;
            step();
        end
    endtask

    task automatic pop();
        host_if.i_rd_en = 1'b1;
        step();
        host_if.i_rd_en = 1'b0;
    endtask

    task automatic frame(input logic [7:0] d, input logic pe, input logic push_ok, input logic rd);
        rx = 1'b0;
        step(); step(); step();
        tick(2);
        rx = 1'b1;
        step(); step();
        rx_done = 1'b1;
        rx_data = d;
        perr_in = pe;
        host_if.i_rd_en = rd;
        if (push_ok) sb.push_back({pe, d});
        step();
        rx_done = 1'b0;
        perr_in = 1'b0;
        host_if.i_rd_en = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] n, input logic e, input logic t);
        cfg_nbd = n; cfg_pen = e; cfg_pt = t; cfg_wr = 1'b1;
    endtask

    initial begin
        host_if.i_rd_en = 1'b0;
        step(); step();
        chk("rst_nbd", 32'(nbd), 32'h3);
        chk("rst_pen_pt_pend", 32'({pen, pt, pending}), 32'h0);
        chk("rst_empty_full", 32'({host_if.o_empty, host_if.o_full}), 32'h2);
        chk("rst_level", 32'(host_if.o_level), 32'h0);
        chk("rst_head", 32'({host_if.o_rd_perr, host_if.o_rd_data}), 32'h0);
        chk("rst_flags", 32'({overrun, frame_to, irq}), 32'h0);
        rst_n = 1'b1;
        step();

        // Three characters, threshold crossing on the second
        frame(8'h41, 1'b0, 1'b1, 1'b0);
        chk("t1_lvl1", 32'(host_if.o_level), 32'h1);
        chk("t1_irq_lo", 32'(irq), 32'h0);
        frame(8'h42, 1'b0, 1'b1, 1'b0);
        chk("t1_irq_hi", 32'(irq), 32'h1);
        frame(8'h43, 1'b0, 1'b1, 1'b0);
        chk("t1_lvl3", 32'(host_if.o_level), 32'h3);
        pop(); pop(); pop();
        chk("t1_empty", 32'(host_if.o_empty), 32'h1);
        chk("t1_irq_off", 32'(irq), 32'h0);
        pop();
        chk("t1_empty_pop_lvl", 32'(host_if.o_level), 32'h0);
        chk("t1_empty_pop_ovr", 32'(overrun), 32'h0);
        chk("t1_head_hold", 32'(host_if.o_rd_data), 32'h43);

        // Configuration written mid-frame is applied only after the frame
        rx = 1'b0;
        step(); step(); step();
        cfg(2'b01, 1'b1, 1'b1);
        step();
        cfg_wr = 1'b0;
        chk("t2_pending", 32'(pending), 32'h1);
        tick(2);
        rx = 1'b1;
        step(); step();
        chk("t2_hold_nbd", 32'({nbd, pen, pt}), 32'h c);
        rx_done = 1'b1; rx_data = 8'h33; sb.push_back(9'h033);
        step();
        rx_done = 1'b0;
        chk("t2_done_edge", 32'({nbd, pen, pt}), 32'hc);
        step();
        chk("t2_applied", 32'({nbd, pen, pt}), 32'h7);
        chk("t2_pend_clr", 32'(pending), 32'h0);
        pop();

        // Character timeout after 64 idle ticks
        frame(8'h55, 1'b0, 1'b1, 1'b0);
        tick(63);
        chk("t3_irq_63", 32'(irq), 32'h0);
        tick(1);
        chk("t3_irq_64", 32'(irq), 32'h1);
        pop();
        chk("t3_irq_pop", 32'(irq), 32'h0);

        // Overrun on full FIFO, then simultaneous pop and push
        for (int i = 0; i < 4; i++) frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0);
        chk("t4_full", 32'({host_if.o_full, host_if.o_level}), 32'h c);
        frame(8'h14, 1'b0, 1'b0, 1'b0);
        chk("t4_ovr", 32'(overrun), 32'h1);
        chk("t4_ovr_lvl", 32'(host_if.o_level), 32'h4);
        chk("t4_ovr_head", 32'(host_if.o_rd_data), 32'h10);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("t4_clr", 32'(overrun), 32'h0);
        frame(8'h15, 1'b0, 1'b1, 1'b1);
        chk("t4_rw_ovr", 32'(overrun), 32'h0);
        chk("t4_rw_lvl", 32'(host_if.o_level), 32'h4);
        chk("t4_rw_head", 32'(host_if.o_rd_data), 32'h11);
        for (int i = 0; i < 4; i++) pop();
        chk("t4_drained", 32'(host_if.o_empty), 32'h1);

        // Watchdog on a stuck-low line
        rx = 1'b0;
        step(); step(); step();
        tick(191);
        chk("t5_wd_191", 32'(frame_to), 32'h0);
        rx = 1'b1;
        step(); step();
        rx_tick = 1'b1; step(); rx_tick = 1'b0;
        chk("t5_wd_192", 32'(frame_to), 32'h1);
        chk("t5_wd_irq", 32'(irq), 32'h1);
        cfg(2'b10, 1'b0, 1'b0);
        step();
        cfg_wr = 1'b0;
        step();
        chk("t5_idle_apply", 32'({nbd, pen, pt}), 32'h8);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("t5_clr", 32'({frame_to, irq}), 32'h0);

        // Write coinciding with the apply cycle
        cfg(2'b00, 1'b1, 1'b0);
        step();
        cfg(2'b01, 1'b0, 1'b1);
        step();
        cfg_wr = 1'b0;
        chk("t6_first", 32'({pending, nbd, pen, pt}), 32'h12);
        step();
        chk("t6_second", 32'({pending, nbd, pen, pt}), 32'h05);

        // Parity error flag, then asynchronous reset mid-frame
        frame(8'h5A, 1'b1, 1'b1, 1'b0);
        chk("t7_perr_head", 32'({host_if.o_rd_perr, host_if.o_rd_data}), 32'h15a);
        pop();
        frame(8'h77, 1'b0, 1'b1, 1'b0);
        rx = 1'b0;
        step(); step(); step();
        cfg(2'b00, 1'b1, 1'b1);
        step();
        cfg_wr = 1'b0;
        tick(1);
        #3 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("t7_rst_cfg", 32'({pending, nbd, pen, pt}), 32'h0c);
        chk("t7_rst_fifo", 32'({host_if.o_empty, host_if.o_full, host_if.o_level}), 32'h10);
        chk("t7_rst_head", 32'({host_if.o_rd_perr, host_if.o_rd_data}), 32'h0);
        chk("t7_rst_flags", 32'({overrun, frame_to, irq}), 32'h0);
        rx = 1'b1;
        step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("t7_cfg_lost", 32'({pending, nbd}), 32'h3);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller between uart_rx and the host.
- Owns the receiver's frame-format configuration and applies host updates only between frames.
- Tracks frame activity on the serial line and buffers received characters with their parity status in a small FIFO.
- Raises an interrupt on a fill threshold or on a character timeout, and flags overrun and stuck-frame errors.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- THRESH, 2, FIFO level at or above which o_irq asserts; range 1..DEPTH.
- TIMEOUT_BITS, 4, idle bit-times before a character timeout; 1 bit-time = 16 rx_tick.
- WDOG_TICKS, 192, maximum rx_tick count allowed within one frame (12 bit-times).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_tick  in  1  16x oversample strobe, shared with uart_rx
- i_rx_serial  in  1  raw serial line; synchronised internally with a 2-flop synchroniser whose reset value is 1
- i_cfg_num_bit_data  in  2  requested data length (00=5 .. 11=8 bits)
- i_cfg_parity_en  in  1  requested parity enable
- i_cfg_parity_type  in  1  requested parity type (0=even, 1=odd)
- i_cfg_wr  in  1  one-cycle strobe that latches the three i_cfg_* fields as pending
- o_num_bit_data  out  2  applied configuration driven to uart_rx
- o_parity_en  out  1  applied configuration driven to uart_rx
- o_parity_type  out  1  applied configuration driven to uart_rx
- o_cfg_pending  out  1  a latched configuration is waiting to be applied
- i_rx_data  in  8  character from uart_rx
- i_rx_done  in  1  one-cycle frame-complete pulse from uart_rx
- i_parity_err  in  1  parity status from uart_rx; valid while i_rx_done is high
- i_rd_en  in  1  host pop strobe
- o_rd_data  out  8  head entry data (show-ahead)
- o_rd_perr  out  1  head entry parity-error flag
- o_empty  out  1  FIFO empty
- o_full  out  1  FIFO full
- o_level  out  clog2(DEPTH)+1  number of entries in the FIFO
- i_clr_err  in  1  clears the sticky error flags
- o_overrun  out  1  sticky: a character was dropped because the FIFO was full
- o_frame_to  out  1  sticky: the frame watchdog expired
- o_irq  out  1  interrupt request

Behaviour:
- Reset values:
  - o_num_bit_data=2'b11, o_parity_en=0, o_parity_type=0, o_cfg_pending=0.
  - FIFO empty: o_empty=1, o_full=0, o_level=0, o_rd_data=0, o_rd_perr=0.
  - o_overrun=0, o_frame_to=0, o_irq=0.
  - FSM in IDLE; all counters 0.
- Frame FSM has two states, IDLE and FRAME.
  - IDLE->FRAME when the synchronised line is 0. Clear the watchdog counter on entry.
  - FRAME->IDLE on i_rx_done.
  - FRAME->IDLE when the watchdog reaches WDOG_TICKS rx_ticks. Set o_frame_to at the same time.
  - FRAME->IDLE on i_rx_done takes priority over watchdog expiry in the same cycle; o_frame_to is not set in that case.
- Configuration:
  - i_cfg_wr latches the requested fields and sets o_cfg_pending. A second i_cfg_wr overwrites the pending values.
  - Apply only when the FSM is in IDLE and the synchronised line is 1. The applied outputs update on the next clock edge and o_cfg_pending clears on that edge.
  - If i_cfg_wr coincides with the apply cycle, the new values become pending and the older values are applied.
- FIFO push:
  - On i_rx_done, push {i_parity_err, i_rx_data}. Write latency is one cycle; o_level updates on the next edge.
  - If the FIFO is full and i_rd_en is not asserted, drop the character, set o_overrun, and leave the contents unchanged.
  - If the FIFO is full and i_rd_en is asserted in the same cycle, both the pop and the push succeed and o_level is unchanged.
- FIFO pop:
  - i_rd_en while not empty pops the head entry. o_rd_data/o_rd_perr always show the head entry.
  - i_rd_en while empty is ignored, with no error.
  - When empty, o_rd_data/o_rd_perr hold their last value.
  - Read and write pointers wrap modulo DEPTH.
- Timeout:
  - The timeout counter counts rx_ticks while the FIFO is non-empty, the FSM is in IDLE, and there is no push or pop.
  - It resets on any push, any pop, or entry to FRAME.
  - At TIMEOUT_BITS*16 ticks, set the internal flag to_flag. It clears on the next pop or when the FIFO becomes empty.
- o_irq is registered: o_irq = (o_level >= THRESH) | to_flag | o_overrun | o_frame_to.
- i_clr_err clears o_overrun and o_frame_to. A set event in the same cycle wins.
- rst_n assertion mid-frame or mid-FIFO aborts everything immediately. Outputs return to reset values asynchronously and any pending configuration is lost.

Test Plan:
- Receive 3 frames 0x41, 0x42, 0x43 with parity off and THRESH=2 -> o_irq rises one cycle after the 2nd done; o_level=3; pops return 0x41, 0x42, 0x43 with o_rd_perr=0; o_empty=1 after the 3rd pop.
- i_cfg_wr with {01,1,1} while in FRAME -> o_cfg_pending=1 and outputs unchanged until done; outputs = 2'b01/1/1 one cycle after IDLE with line high.
- Fill DEPTH=4 FIFO, then a 5th done with no read -> o_overrun=1, o_level=4, head still the 1st char; repeat with i_rd_en on the done cycle -> no overrun, o_level stays 4.
- One character left unread and line idle for 64 rx_ticks -> o_irq=1; a pop -> o_irq=0, provided no error flags are set.
- Line held low with no done for 192 rx_ticks -> o_frame_to=1, FSM back in IDLE; i_clr_err -> o_frame_to=0.
- Frame with i_parity_err=1 on done -> entry read back with o_rd_perr=1; assert rst_n low mid-frame -> all outputs at reset values within the same cycle.
